// File: rtl/aes_pkg.sv
// Shared AES constants: block width, core pipeline depth, sel encoding,
// plus the result-collector mode FSM states and FIFO entry layout.
package aes_pkg;

    localparam int AES_BLOCK_W      = 128;
    localparam int AES_PIPE_LATENCY = 10;

    localparam logic AES_ENC = 1'b0;
    localparam logic AES_DEC = 1'b1;

    typedef enum logic {
        MODE_RUN   = 1'b0,
        MODE_DRAIN = 1'b1
    } mode_state_t;

    // One buffered core result: mode tag on top of the 128-bit block.
    typedef struct packed {
        logic                   sel;
        logic [AES_BLOCK_W-1:0] data;
    } aes_result_t;

endpackage

// File: rtl/aes_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// DEPTH must be a power of two so the pointers wrap on their own.
module aes_sync_fifo #(
    parameter  int WIDTH = 129,
    parameter  int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             pop_valid,
    output logic [CNT_W-1:0] cnt
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A pop on an empty FIFO is dropped; a push into a full one only lands
    // when a pop frees the slot in the same cycle.
    assign do_pop  = pop & (cnt != '0);
    assign do_push = push & ((cnt != CNT_W'(DEPTH)) | do_pop);

    assign pop_valid = (cnt != '0);
    assign pop_data  = pop_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/aes_out_fifo.sv
// Result collector for the aes128_pip core: valid-tag shadow pipeline, credit
// flow control, output FIFO and mode FSM. Optional stats: AES_OUT_FIFO_STATS_EN.
module aes_out_fifo
    import aes_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int LATENCY = AES_PIPE_LATENCY
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s_valid,
    input  logic                   s_sel,
    output logic                   s_ready,
    output logic                   pipe_sel,
    input  logic [AES_BLOCK_W-1:0] pipe_out,
    output logic [AES_BLOCK_W-1:0] m_data,
    output logic                   m_sel,
    output logic                   m_valid,
`ifdef AES_OUT_FIFO_STATS_EN
    input  logic                   m_ready,
    output logic [31:0]            stat_blocks,
    output logic [31:0]            stat_stall
`else
    input  logic                   m_ready
`endif
);

    localparam int INFL_W = $clog2(LATENCY + 1);
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic [LATENCY-1:0] tag;
    logic               launch;
    logic               cap;
    logic               pop;
    logic [INFL_W-1:0]  infl;
    logic [CNT_W-1:0]   fifo_cnt;
    logic [31:0]        credit_used;
    mode_state_t        state;
    mode_state_t        state_nxt;
    logic               switching;
    logic               flip;
    logic               pend_sel;
    logic               flip_sel;
    aes_result_t        push_entry;
    aes_result_t        head;

    // Every block already in flight owns a FIFO slot, so capture can never
    // find the FIFO full.
    assign credit_used = 32'(fifo_cnt) + 32'(infl);
    assign s_ready     = (credit_used < 32'(DEPTH)) & (s_sel == pipe_sel) & !switching;
    assign launch      = s_valid & s_ready;
    assign cap         = tag[LATENCY-1];
    assign pop         = m_valid & m_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag  <= '0;
            infl <= '0;
        end else begin
            tag <= {tag[LATENCY-2:0], launch};
            case ({launch, cap})
                2'b10:   infl <= infl + INFL_W'(1);
                2'b01:   infl <= infl - INFL_W'(1);
                default: infl <= infl;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        switching = 1'b0;
        flip      = 1'b0;
        case (state)
            MODE_RUN: begin
                if (s_valid && (s_sel != pipe_sel)) begin
                    state_nxt = MODE_DRAIN;
                end
            end
            MODE_DRAIN: begin
                switching = 1'b1;
                if (infl == '0) begin
                    state_nxt = MODE_RUN;
                    flip      = 1'b1;
                end
            end
            default: state_nxt = MODE_RUN;
        endcase
    end

    // If the requester withdraws during the drain, flip to the mode it last asked for.
    assign flip_sel = s_valid ? s_sel : pend_sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= MODE_RUN;
            pipe_sel <= AES_ENC;
            pend_sel <= AES_ENC;
        end else begin
            state <= state_nxt;
            if (s_valid) begin
                pend_sel <= s_sel;
            end
            if (flip) begin
                pipe_sel <= flip_sel;
            end
        end
    end

    assign push_entry = '{sel: pipe_sel, data: pipe_out};

    aes_sync_fifo #(
        .WIDTH ($bits(aes_result_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cap),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head),
        .pop_valid (m_valid),
        .cnt       (fifo_cnt)
    );

    assign m_data = head.data;
    assign m_sel  = head.sel;

`ifdef AES_OUT_FIFO_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_blocks <= '0;
            stat_stall  <= '0;
        end else begin
            if (pop) begin
                stat_blocks <= stat_blocks + 32'd1;
            end
            if (s_valid && !s_ready) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_aes_out_fifo.sv
// Self-checking bench for aes_out_fifo with a stand-in 10-stage core and a
// queue-based reference model of tags, credits, FIFO and mode switching.
module tb_aes_out_fifo;
    import aes_pkg::*;

    localparam int DEPTH = 16;
    localparam int LAT   = AES_PIPE_LATENCY;
    localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         s_valid = 1'b0;
    logic         s_sel = 1'b0;
    logic         s_ready;
    logic         pipe_sel;
    logic [127:0] pipe_out;
    logic [127:0] m_data;
    logic         m_sel;
    logic         m_valid;
    logic         m_ready = 1'b0;
    logic [127:0] core_in = '0;
    logic [127:0] core_q [LAT];
`ifdef AES_OUT_FIFO_STATS_EN
    logic [31:0]  stat_blocks;
    logic [31:0]  stat_stall;
`endif

    aes_out_fifo #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_sel    (s_sel),
        .s_ready  (s_ready),
        .pipe_sel (pipe_sel),
        .pipe_out (pipe_out),
        .m_data   (m_data),
        .m_sel    (m_sel),
        .m_valid  (m_valid),
`ifdef AES_OUT_FIFO_STATS_EN
        .m_ready  (m_ready),
        .stat_blocks (stat_blocks),
        .stat_stall  (stat_stall)
`else
        .m_ready  (m_ready)
`endif
    );

    always #5 clk = ~clk;

    // Stand-in core: knows the FIPS-197 vector, otherwise a keyed scramble.
    function automatic logic [127:0] core_fn(input logic [127:0] d, input logic sel);
        if (!sel && d == PT) return CT;
        if (sel && d == CT) return PT;
        if (sel) return {d[63:0], d[127:64]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
        return {d[31:0], d[127:32]} ^ 128'hdeadbeef0123456789abcdeffedcba98;
    endfunction

    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) core_q[i] <= core_q[i-1];
        core_q[0] <= core_fn(core_in, pipe_sel);
    end
    assign pipe_out = core_q[LAT-1];

    typedef struct { logic [127:0] data; logic sel; int due; } flight_t;
    typedef struct { logic [127:0] data; logic sel; } entry_t;
    typedef struct {
        logic v; logic sel; logic rdy; logic [127:0] din;
        logic exp_ready; logic exp_valid; logic [127:0] exp_data; logic exp_sel;
    } vec_t;

    flight_t infl_q[$];
    entry_t  fifo_q[$];
    int      obs_due[$];
    int      obs_occ;
    logic    md_sel, md_drain, md_last;
    logic    exp_ready;
    int      cycle_no, pop_cnt, stall_cnt;
    int      errors = 0;
    int      checks = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic clearModel();
        infl_q.delete(); fifo_q.delete(); obs_due.delete();
        obs_occ = 0; md_sel = AES_ENC; md_drain = 1'b0; md_last = AES_ENC;
        pop_cnt = 0; stall_cnt = 0;
    endtask

    task automatic applyStimulus(input logic v, input logic sel, input logic [127:0] din, input logic rdy);
        @(negedge clk);
        s_valid = v; s_sel = sel; core_in = din; m_ready = rdy;
        #1;
    endtask

    task automatic checkOutput();
        exp_ready = (fifo_q.size() + infl_q.size() < DEPTH) && (s_sel == md_sel) && !md_drain;
        chk("s_ready", s_ready, exp_ready);
        chk("m_valid", m_valid, fifo_q.size() != 0);
        chk("pipe_sel", pipe_sel, md_sel);
        if (fifo_q.size() != 0) begin
            chk("m_data", m_data, fifo_q[0].data);
            chk("m_sel", m_sel, fifo_q[0].sel);
        end
`ifdef AES_OUT_FIFO_STATS_EN
        chk("stat_blocks", stat_blocks, pop_cnt);
        chk("stat_stall", stat_stall, stall_cnt);
`endif
    endtask

    // Advances the model across the coming rising edge using pre-edge inputs.
    task automatic updateModel();
        int      pre_infl;
        int      pre_fifo;
        int      pre_obs;
        flight_t f;
        entry_t  e;
        pre_infl = infl_q.size();
        pre_fifo = fifo_q.size();
        pre_obs  = obs_occ;
        if (s_valid && !exp_ready) stall_cnt++;
        if (m_ready && pre_fifo != 0) begin
            void'(fifo_q.pop_front());
            pop_cnt++;
        end
        if (pre_infl != 0 && infl_q[0].due == cycle_no) begin
            f = infl_q.pop_front();
            e.data = f.data; e.sel = f.sel;
            fifo_q.push_back(e);
        end
        if (s_valid && exp_ready) begin
            f.data = core_fn(core_in, md_sel); f.sel = md_sel; f.due = cycle_no + LAT;
            infl_q.push_back(f);
        end
        // Occupancy as seen purely from the DUT's own handshakes.
        if (m_valid && m_ready && obs_occ > 0) obs_occ--;
        if (obs_due.size() != 0 && obs_due[0] == cycle_no) begin
            void'(obs_due.pop_front());
            chk("push_into_full", pre_obs < DEPTH, 1'b1);
            obs_occ++;
        end
        if (s_valid && s_ready) obs_due.push_back(cycle_no + LAT);
        if (!md_drain) begin
            if (s_valid && s_sel != md_sel) md_drain = 1'b1;
        end else if (pre_infl == 0) begin
            md_sel   = s_valid ? s_sel : md_last;
            md_drain = 1'b0;
        end
        if (s_valid) md_last = s_sel;
        cycle_no++;
    endtask

    task automatic runCycle(input logic v, input logic sel, input logic [127:0] din, input logic rdy);
        applyStimulus(v, sel, din, rdy);
        checkOutput();
        updateModel();
    endtask

    task automatic doReset();
        @(negedge clk);
        #3 rst = 1'b1;
        #1;
        chk("reset_m_valid", m_valid, 1'b0);
        chk("reset_m_sel", m_sel, 1'b0);
        s_valid = 1'b0; s_sel = 1'b0; m_ready = 1'b0;
        clearModel();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t   vecs[13];
        int     acc, refused, popped;
        logic   dec_seen;
        logic   sel_now;

        cycle_no = 0;
        clearModel();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_reset_m_valid", m_valid, 1'b0);
        chk("post_reset_m_sel", m_sel, 1'b0);
        chk("post_reset_pipe_sel", pipe_sel, AES_ENC);
`ifdef AES_OUT_FIFO_STATS_EN
        chk("post_reset_stat_blocks", stat_blocks, 32'd0);
        chk("post_reset_stat_stall", stat_stall, 32'd0);
`endif

        // FIPS-197 single block: launch at row 0, result visible at row 11.
        for (int i = 0; i < 13; i++) begin
            vecs[i] = '{v: 1'b0, sel: AES_ENC, rdy: 1'b1, din: '0,
                        exp_ready: 1'b1, exp_valid: 1'b0, exp_data: '0, exp_sel: 1'b0};
        end
        vecs[0].v = 1'b1;
        vecs[0].din = PT;
        vecs[11].exp_valid = 1'b1;
        vecs[11].exp_data  = CT;
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].v, vecs[i].sel, vecs[i].din, vecs[i].rdy);
            checkOutput();
            chk($sformatf("fips_row%0d_s_ready", i), s_ready, vecs[i].exp_ready);
            chk($sformatf("fips_row%0d_m_valid", i), m_valid, vecs[i].exp_valid);
            if (vecs[i].exp_valid) begin
                chk($sformatf("fips_row%0d_m_data", i), m_data, vecs[i].exp_data);
                chk($sformatf("fips_row%0d_m_sel", i), m_sel, vecs[i].exp_sel);
            end
            updateModel();
        end

        // Backpressure: 30 cycles of continuous requests with the sink stalled.
        doReset();
        acc = 0; refused = 0; popped = 0;
        for (int i = 0; i < 30; i++) begin
            applyStimulus(1'b1, AES_ENC, rnd128(), 1'b0);
            if (s_ready) acc++; else refused++;
            checkOutput();
            updateModel();
        end
        chk("bp_accepted", acc, 16);
        chk("bp_refused", refused, 14);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, AES_ENC, '0, 1'b1);
            if (m_valid) popped++;
            checkOutput();
            updateModel();
        end
        chk("bp_popped", popped, 16);
`ifdef AES_OUT_FIFO_STATS_EN
        applyStimulus(1'b0, AES_ENC, '0, 1'b1);
        chk("bp_stat_blocks", stat_blocks, 32'd16);
        chk("bp_stat_stall", stat_stall, 32'd14);
        checkOutput();
        updateModel();
`endif

        // Back-to-back launches: push and pop coincide while one entry is held.
        runCycle(1'b1, AES_ENC, rnd128(), 1'b1);
        runCycle(1'b1, AES_ENC, rnd128(), 1'b1);
        for (int i = 0; i < 14; i++) runCycle(1'b0, AES_ENC, '0, 1'b1);

        // Mode switch: three encrypts in flight, then a decrypt request.
        for (int i = 0; i < 3; i++) runCycle(1'b1, AES_ENC, rnd128(), 1'b1);
        refused = 0;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b1, AES_DEC, CT, 1'b1);
            acc = s_ready ? 1 : 0;
            checkOutput();
            updateModel();
            if (acc == 1) break;
            refused++;
        end
        chk("switch_refused_cycles", refused, 11);
        dec_seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            applyStimulus(1'b0, AES_DEC, '0, 1'b1);
            if (m_valid && m_sel == AES_DEC && m_data == PT) dec_seen = 1'b1;
            checkOutput();
            updateModel();
        end
        chk("decrypt_result", dec_seen, 1'b1);
        // Request to go back, withdrawn immediately; the drain still completes.
        runCycle(1'b1, AES_ENC, rnd128(), 1'b1);
        for (int i = 0; i < 4; i++) runCycle(1'b0, AES_DEC, '0, 1'b1);
        chk("withdrawn_switch_pipe_sel", pipe_sel, AES_ENC);

        // Reset with 5 in flight and 4 buffered.
        for (int i = 0; i < 9; i++) runCycle(1'b1, AES_ENC, rnd128(), 1'b0);
        for (int i = 0; i < 5; i++) runCycle(1'b0, AES_ENC, '0, 1'b0);
        doReset();
        for (int i = 0; i < 20; i++) runCycle(1'b0, AES_ENC, '0, 1'b1);

        // Randomized traffic with occasional mode changes.
        sel_now = AES_ENC;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 15) == 0) sel_now = ~sel_now;
            runCycle($urandom_range(0, 3) != 0, sel_now, rnd128(), $urandom_range(0, 2) != 0);
        end
        for (int i = 0; i < 30; i++) runCycle(1'b0, sel_now, '0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
